// File: rtl/dma_apb_slave_pkg.sv
// Shared constants for the DMA APB completer.
// Holds the FSM width and state encodings used by dma_apb_slave. The states
// are plain localparam constants so that legacy code can compare against them
// directly. Also holds the width of the wait-state counter.
// No ports; this file is imported by the top module and the register file.
package dma_apb_slave_pkg;

    localparam int DMA_APB_SLV_FSM_WIDTH = 2;

    localparam logic [DMA_APB_SLV_FSM_WIDTH-1:0] FSM_DMA_APB_SLV_IDLE   = 2'd0;
    localparam logic [DMA_APB_SLV_FSM_WIDTH-1:0] FSM_DMA_APB_SLV_WAIT   = 2'd1;
    localparam logic [DMA_APB_SLV_FSM_WIDTH-1:0] FSM_DMA_APB_SLV_ACCESS = 2'd2;

    // Wait-state counter width; it covers the range 0..15.
    localparam int DMA_APB_SLV_CNT_WIDTH = 4;

endpackage

// File: rtl/dma_apb_slv_regfile.sv
// Register bank for the DMA APB completer.
// Holds REG_NUM words of DATA_WIDTH bits. Entry 0 is a read-only ID constant.
// All other entries are read/write through a single write port. A single
// combinational read port is also provided.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset; clears all writable entries
//   wr_en    - write strobe
//   wr_idx   - word index written when wr_en is high
//   wr_data  - data written
//   rd_idx   - word index read
//   rd_data  - read data (ID_VALUE when rd_idx is 0)
module dma_apb_slv_regfile
    import dma_apb_slave_pkg::*;
#(
    parameter int                    REG_NUM    = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'hD0A1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(REG_NUM)-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [$clog2(REG_NUM)-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]      rd_data
);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    // Entry 0 is never written. The index check here is kept even though the
    // top module already filters out index 0, so the ID cannot be disturbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_idx != '0)) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign rd_data = (rd_idx == '0) ? ID_VALUE : regs[rd_idx];

endmodule

// File: rtl/dma_apb_slave.sv
// APB completer that terminates transfers issued by the DMA APB initiator.
// It decodes the encoded select bus against SLV_INDEX. It then inserts
// WAIT_CYCLES wait states and serves a word-addressed register bank. Entry 0
// of the bank is a read-only ID. Each committed register write raises a
// one-cycle notification for the backend.
// Optional feature: define DMA_APB_SLV_PSLVERR_EN to drive o_pslverr for
// out-of-range accesses and for writes to the ID register. When the macro is
// undefined, o_pslverr is tied low. Those accesses are then dropped silently:
// reads return 0 and writes are ignored.
// Ports:
//   pclk       - clock
//   preset     - synchronous active-high reset
//   i_psel     - encoded slave select
//   i_psel_vld - select bus valid (PSEL)
//   i_penable  - APB access phase
//   i_pwrite   - 1 = write, 0 = read
//   i_paddr    - byte address
//   i_pwdata   - write data
//   o_pready   - transfer completes this cycle
//   o_prdata   - read data, valid while o_pready is high
//   o_pslverr  - error response, qualified by o_pready
//   o_reg_wr   - one-cycle pulse after a register write commits
//   o_reg_idx  - index of the committed write
module dma_apb_slave
    import dma_apb_slave_pkg::*;
#(
    parameter int                        APB_SVL        = 4,
    parameter int                        APB_ADDR_WIDTH = 16,
    parameter int                        APB_DATA_WIDTH = 16,
    parameter int                        SLV_INDEX      = 0,
    parameter int                        REG_NUM        = 8,
    parameter int                        WAIT_CYCLES    = 0,
    parameter logic [APB_DATA_WIDTH-1:0] ID_VALUE       = 16'hD0A1
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic [$clog2(APB_SVL)-1:0]  i_psel,
    input  logic                        i_psel_vld,
    input  logic                        i_penable,
    input  logic                        i_pwrite,
    input  logic [APB_ADDR_WIDTH-1:0]   i_paddr,
    input  logic [APB_DATA_WIDTH-1:0]   i_pwdata,
    output logic                        o_pready,
    output logic [APB_DATA_WIDTH-1:0]   o_prdata,
    output logic                        o_pslverr,
    output logic                        o_reg_wr,
    output logic [$clog2(REG_NUM)-1:0]  o_reg_idx
);

    localparam int SEL_W    = $clog2(APB_SVL);
    localparam int IDX_W    = $clog2(REG_NUM);
    localparam int ADDR_LSB = $clog2(APB_DATA_WIDTH / 8);
    localparam int IDX_HI   = ADDR_LSB + IDX_W;

    localparam logic [SEL_W-1:0]                 SLV_SEL  = SEL_W'(SLV_INDEX);
    localparam logic [DMA_APB_SLV_CNT_WIDTH-1:0] WAIT_CNT = DMA_APB_SLV_CNT_WIDTH'(WAIT_CYCLES);

    logic                             sel;
    logic [IDX_W-1:0]                 idx;
    logic                             oor;
    logic [DMA_APB_SLV_FSM_WIDTH-1:0] state;
    logic [DMA_APB_SLV_CNT_WIDTH-1:0] cnt;
    logic [IDX_W-1:0]                 idx_q;
    logic                             oor_q;
    logic                             write_q;
    logic                             commit;
    logic [APB_DATA_WIDTH-1:0]        rd_data;

    assign sel = i_psel_vld && (i_psel == SLV_SEL);
    assign idx = i_paddr[ADDR_LSB +: IDX_W];

    // Any address bit above the register window makes the access out of
    // range. The byte-offset bits below ADDR_LSB are ignored.
    assign oor = (i_paddr >> IDX_HI) != '0;

    // Ready is held low during reset. A reset that lands in ACCESS therefore
    // never shows a completion to the initiator.
    assign o_pready = (state == FSM_DMA_APB_SLV_ACCESS) && sel && i_penable && !preset;

    // Index 0 holds the ID and out-of-range addresses alias nothing, so
    // neither may reach the register bank.
    assign commit = o_pready && i_pwrite && !oor_q && (idx_q != '0);

`ifdef DMA_APB_SLV_PSLVERR_EN
    assign o_pslverr = o_pready && (oor_q || (i_pwrite && (idx_q == '0)));
`else
    assign o_pslverr = 1'b0;
`endif

    // Transfer FSM. The address and direction are captured at the setup
    // phase. Later address changes during the stall therefore do not matter.
    // An access phase with no preceding setup is ignored.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state   <= FSM_DMA_APB_SLV_IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            write_q <= 1'b0;
        end else begin
            case (state)
                FSM_DMA_APB_SLV_IDLE: begin
                    if (sel && !i_penable) begin
                        state   <= FSM_DMA_APB_SLV_WAIT;
                        cnt     <= WAIT_CNT;
                        idx_q   <= idx;
                        oor_q   <= oor;
                        write_q <= i_pwrite;
                    end
                end
                FSM_DMA_APB_SLV_WAIT: begin
                    if (!sel) begin
                        state <= FSM_DMA_APB_SLV_IDLE;
                    end else if (cnt == '0) begin
                        state <= FSM_DMA_APB_SLV_ACCESS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FSM_DMA_APB_SLV_ACCESS: begin
                    if (!sel || o_pready) begin
                        state <= FSM_DMA_APB_SLV_IDLE;
                    end
                end
                default: begin
                    state <= FSM_DMA_APB_SLV_IDLE;
                end
            endcase
        end
    end

    // Read data is captured once, as the FSM enters ACCESS. It then stays
    // stable for the whole access phase and holds until the next read.
    always_ff @(posedge pclk) begin
        if (preset) begin
            o_prdata <= '0;
        end else if ((state == FSM_DMA_APB_SLV_WAIT) && sel && (cnt == '0) && !write_q) begin
            o_prdata <= oor_q ? '0 : rd_data;
        end
    end

    // The backend notification follows the commit edge by one cycle.
    // The reported index stays valid until the next commit.
    always_ff @(posedge pclk) begin
        if (preset) begin
            o_reg_wr  <= 1'b0;
            o_reg_idx <= '0;
        end else begin
            o_reg_wr <= commit;
            if (commit) begin
                o_reg_idx <= idx_q;
            end
        end
    end

    dma_apb_slv_regfile #(
        .REG_NUM    (REG_NUM),
        .DATA_WIDTH (APB_DATA_WIDTH),
        .ID_VALUE   (ID_VALUE)
    ) u_regfile (
        .clk     (pclk),
        .rst     (preset),
        .wr_en   (commit),
        .wr_idx  (idx_q),
        .wr_data (i_pwdata),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_dma_apb_slave.sv
// Testbench for dma_apb_slave.
// Two instances share one APB bus:
//   dut0 - SLV_INDEX 2, no wait states
//   dut3 - SLV_INDEX 3, three wait states
// Each scenario task drives directed vectors and compares the results against
// hand-computed values. Honours DMA_APB_SLV_PSLVERR_EN for the expected error
// response.
module tb_dma_apb_slave;

`ifdef DMA_APB_SLV_PSLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  psel;
    logic        psel_vld;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [15:0] pwdata;

    logic        ready0, err0, regwr0;
    logic [15:0] rdata0;
    logic [2:0]  regidx0;
    logic        ready3, err3, regwr3;
    logic [15:0] rdata3;
    logic [2:0]  regidx3;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 pclk = ~pclk;

    // Counts rising edges; used to prove that back-to-back transfers take no idle cycle.
    always @(posedge pclk) cycle++;

    dma_apb_slave #(
        .APB_SVL(4), .APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16), .SLV_INDEX(2),
        .REG_NUM(8), .WAIT_CYCLES(0), .ID_VALUE(16'hD0A1)
    ) dut0 (
        .pclk(pclk), .preset(preset), .i_psel(psel), .i_psel_vld(psel_vld),
        .i_penable(penable), .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
        .o_pready(ready0), .o_prdata(rdata0), .o_pslverr(err0),
        .o_reg_wr(regwr0), .o_reg_idx(regidx0)
    );

    dma_apb_slave #(
        .APB_SVL(4), .APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(16), .SLV_INDEX(3),
        .REG_NUM(8), .WAIT_CYCLES(3), .ID_VALUE(16'hD0A1)
    ) dut3 (
        .pclk(pclk), .preset(preset), .i_psel(psel), .i_psel_vld(psel_vld),
        .i_penable(penable), .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
        .o_pready(ready3), .o_prdata(rdata3), .o_pslverr(err3),
        .o_reg_wr(regwr3), .o_reg_idx(regidx3)
    );

    // Bus driver for one complete APB transfer.
    // The task is entered 1 time unit after a rising edge and returns 1 time
    // unit after the completion edge, with the bus released. Consecutive calls
    // therefore run back to back. Stalls counts penable cycles seen with ready
    // low.
    task automatic apb_xfer(input logic [1:0] s, input logic [15:0] addr, input logic w,
                            input logic [15:0] wd, output int stalls, output logic [15:0] rd,
                            output logic err, output logic wr_pulse, output logic [2:0] wr_idx,
                            output logic timed_out);
        logic rdy;
        logic got;
        got = 1'b0; stalls = 0; rd = '0; err = 1'b0; wr_pulse = 1'b0; wr_idx = '0;
        psel = s; psel_vld = 1'b1; penable = 1'b0; pwrite = w; paddr = addr; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            rdy = (s == 2'd2) ? ready0 : ready3;
            if (rdy) begin
                got = 1'b1;
                rd  = (s == 2'd2) ? rdata0 : rdata3;
                err = (s == 2'd2) ? err0 : err3;
                break;
            end
            stalls++;
            @(posedge pclk); #1;
        end
        if (got) begin
            @(posedge pclk); #1;
            wr_pulse = (s == 2'd2) ? regwr0 : regwr3;
            wr_idx   = (s == 2'd2) ? regidx0 : regidx3;
        end
        timed_out = !got;
        psel_vld = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1; psel = '0; psel_vld = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        checks++; if ((ready0 | ready3) !== 1'b0) begin failures++; $display("[TB] FAIL reset_pready got=%b exp=0", ready0 | ready3); end
        checks++; if (rdata0 !== 16'h0000) begin failures++; $display("[TB] FAIL reset_prdata0 got=%h exp=0000", rdata0); end
        checks++; if (rdata3 !== 16'h0000) begin failures++; $display("[TB] FAIL reset_prdata3 got=%h exp=0000", rdata3); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_pslverr got=%b exp=0", err0); end
        checks++; if (regwr0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_reg_wr got=%b exp=0", regwr0); end
        checks++; if (regidx0 !== 3'd0) begin failures++; $display("[TB] FAIL reset_reg_idx got=%0d exp=0", regidx0); end
    endtask

    task automatic test_write_read();
        int st; logic [15:0] rd; logic er, wp, to; logic [2:0] wi;
        @(posedge pclk); #1;
        apb_xfer(2'd2, 16'h0004, 1'b1, 16'h1234, st, rd, er, wp, wi, to);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL wr_timeout got=%b exp=0", to); end
        checks++; if (st != 1) begin failures++; $display("[TB] FAIL wr_stalls got=%0d exp=1", st); end
        checks++; if (wp !== 1'b1) begin failures++; $display("[TB] FAIL wr_pulse got=%b exp=1", wp); end
        checks++; if (wi !== 3'd2) begin failures++; $display("[TB] FAIL wr_idx got=%0d exp=2", wi); end
        checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL wr_pslverr got=%b exp=0", er); end
        checks++; if (ready0 !== 1'b0) begin failures++; $display("[TB] FAIL wr_ready_one_cycle got=%b exp=0", ready0); end
        @(posedge pclk); #1;
        checks++; if (regwr0 !== 1'b0) begin failures++; $display("[TB] FAIL wr_pulse_width got=%b exp=0", regwr0); end
        apb_xfer(2'd2, 16'h0004, 1'b0, 16'h0000, st, rd, er, wp, wi, to);
        checks++; if (st != 1) begin failures++; $display("[TB] FAIL rd_stalls got=%0d exp=1", st); end
        checks++; if (rd !== 16'h1234) begin failures++; $display("[TB] FAIL rd_data got=%h exp=1234", rd); end
        checks++; if (wp !== 1'b0) begin failures++; $display("[TB] FAIL rd_no_pulse got=%b exp=0", wp); end
    endtask

    task automatic test_wait_states();
        int st; logic [15:0] rd; logic er, wp, to; logic [2:0] wi;
        @(posedge pclk); #1;
        apb_xfer(2'd3, 16'h0000, 1'b0, 16'h0000, st, rd, er, wp, wi, to);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL ws_timeout got=%b exp=0", to); end
        checks++; if (st != 4) begin failures++; $display("[TB] FAIL ws_stalls got=%0d exp=4", st); end
        checks++; if (rd !== 16'hD0A1) begin failures++; $display("[TB] FAIL ws_id got=%h exp=d0a1", rd); end
    endtask

    task automatic test_not_selected();
        int st; logic [15:0] rd; logic er, wp, to; logic [2:0] wi;
        logic seen;
        seen = 1'b0;
        @(posedge pclk); #1;
        psel = 2'd1; psel_vld = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004; pwdata = 16'hFFFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            if (ready0 || ready3 || regwr0 || regwr3) seen = 1'b1;
        end
        @(posedge pclk); #1;
        psel_vld = 1'b0; penable = 1'b0;
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL nosel_activity got=%b exp=0", seen); end
        apb_xfer(2'd2, 16'h0004, 1'b0, 16'h0000, st, rd, er, wp, wi, to);
        checks++; if (rd !== 16'h1234) begin failures++; $display("[TB] FAIL nosel_reg_kept got=%h exp=1234", rd); end
    endtask

    task automatic test_abort();
        int st; logic [15:0] rd; logic er, wp, to; logic [2:0] wi;
        logic seen;
        seen = 1'b0;
        @(posedge pclk); #1;
        psel = 2'd3; psel_vld = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0006; pwdata = 16'hAAAA;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel_vld = 1'b0; penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (ready3 || regwr3) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL abort_activity got=%b exp=0", seen); end
        @(posedge pclk); #1;
        apb_xfer(2'd3, 16'h0006, 1'b0, 16'h0000, st, rd, er, wp, wi, to);
        checks++; if (st != 4) begin failures++; $display("[TB] FAIL abort_rd_stalls got=%0d exp=4", st); end
        checks++; if (rd !== 16'h0000) begin failures++; $display("[TB] FAIL abort_no_commit got=%h exp=0000", rd); end
        apb_xfer(2'd3, 16'h0006, 1'b1, 16'h5555, st, rd, er, wp, wi, to);
        checks++; if (st != 4) begin failures++; $display("[TB] FAIL abort_wr_stalls got=%0d exp=4", st); end
        checks++; if (wp !== 1'b1 || wi !== 3'd3) begin failures++; $display("[TB] FAIL abort_wr_pulse got=%b/%0d exp=1/3", wp, wi); end
        apb_xfer(2'd3, 16'h0006, 1'b0, 16'h0000, st, rd, er, wp, wi, to);
        checks++; if (rd !== 16'h5555) begin failures++; $display("[TB] FAIL abort_rd_after got=%h exp=5555", rd); end
    endtask

    task automatic test_error();
        int st; logic [15:0] rd; logic er, wp, to; logic [2:0] wi;
        @(posedge pclk); #1;
        apb_xfer(2'd2, 16'h0000, 1'b1, 16'hBEEF, st, rd, er, wp, wi, to);
        checks++; if (er !== EXP_ERR) begin failures++; $display("[TB] FAIL err_wr_id got=%b exp=%b", er, EXP_ERR); end
        checks++; if (wp !== 1'b0) begin failures++; $display("[TB] FAIL err_wr_id_pulse got=%b exp=0", wp); end
        apb_xfer(2'd2, 16'h0000, 1'b0, 16'h0000, st, rd, er, wp, wi, to);
        checks++; if (rd !== 16'hD0A1) begin failures++; $display("[TB] FAIL err_id_kept got=%h exp=d0a1", rd); end
        checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL err_rd_id got=%b exp=0", er); end
        apb_xfer(2'd2, 16'h0100, 1'b0, 16'h0000, st, rd, er, wp, wi, to);
        checks++; if (rd !== 16'h0000) begin failures++; $display("[TB] FAIL err_oor_rd got=%h exp=0000", rd); end
        checks++; if (er !== EXP_ERR) begin failures++; $display("[TB] FAIL err_oor_rd_err got=%b exp=%b", er, EXP_ERR); end
        apb_xfer(2'd2, 16'h0104, 1'b1, 16'h9999, st, rd, er, wp, wi, to);
        checks++; if (wp !== 1'b0) begin failures++; $display("[TB] FAIL err_oor_wr_pulse got=%b exp=0", wp); end
        checks++; if (er !== EXP_ERR) begin failures++; $display("[TB] FAIL err_oor_wr_err got=%b exp=%b", er, EXP_ERR); end
        apb_xfer(2'd2, 16'h0004, 1'b0, 16'h0000, st, rd, er, wp, wi, to);
        checks++; if (rd !== 16'h1234) begin failures++; $display("[TB] FAIL err_oor_no_alias got=%h exp=1234", rd); end
    endtask

    task automatic test_back_to_back();
        int st; logic [15:0] rd; logic er, wp, to; logic [2:0] wi;
        int start;
        @(posedge pclk); #1;
        start = cycle;
        for (int i = 1; i <= 7; i++) begin
            apb_xfer(2'd2, 16'(i * 2), 1'b1, 16'(i), st, rd, er, wp, wi, to);
            checks++; if (st != 1 || wp !== 1'b1 || wi !== 3'(i)) begin
                failures++; $display("[TB] FAIL b2b_wr%0d got=stall%0d/pulse%b/idx%0d exp=stall1/pulse1/idx%0d", i, st, wp, wi, i);
            end
        end
        checks++; if ((cycle - start) != 21) begin failures++; $display("[TB] FAIL b2b_wr_cycles got=%0d exp=21", cycle - start); end
        start = cycle;
        for (int i = 1; i <= 7; i++) begin
            apb_xfer(2'd2, 16'(i * 2), 1'b0, 16'h0000, st, rd, er, wp, wi, to);
            checks++; if (rd !== 16'(i)) begin failures++; $display("[TB] FAIL b2b_rd%0d got=%h exp=%h", i, rd, 16'(i)); end
        end
        checks++; if ((cycle - start) != 21) begin failures++; $display("[TB] FAIL b2b_rd_cycles got=%0d exp=21", cycle - start); end
    endtask

    task automatic test_reset_mid();
        int st; logic [15:0] rd; logic er, wp, to; logic [2:0] wi;
        @(posedge pclk); #1;
        psel = 2'd2; psel_vld = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000A; pwdata = 16'h7777;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(negedge pclk);
        checks++; if (ready0 !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_pready got=%b exp=0", ready0); end
        @(posedge pclk); #1;
        preset = 1'b0; psel_vld = 1'b0; penable = 1'b0;
        @(negedge pclk);
        checks++; if (ready0 !== 1'b0 || regwr0 !== 1'b0 || regidx0 !== 3'd0 || rdata0 !== 16'h0000) begin
            failures++; $display("[TB] FAIL rstmid_outputs got=%b/%b/%0d/%h exp=0/0/0/0000", ready0, regwr0, regidx0, rdata0);
        end
        @(posedge pclk); #1;
        apb_xfer(2'd2, 16'h000A, 1'b0, 16'h0000, st, rd, er, wp, wi, to);
        checks++; if (rd !== 16'h0000) begin failures++; $display("[TB] FAIL rstmid_reg5 got=%h exp=0000", rd); end
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_timeout got=%b exp=0", to); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_not_selected();
        test_abort();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
